// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
// Takes a length-prefixed byte stream (LEN_HI, LEN_LO, N*4 payload bytes,
// XOR checksum). It packs the payload into big-endian 32-bit words and writes
// them to consecutive word addresses. The core is kept in reset until a
// complete image has been loaded and its checksum has been verified.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_run,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  // The word count is 16 bits wide, so the limit is widened by one bit for an
  // unsigned comparison that cannot overflow.
  localparam logic [16:0] DepthC = 17'(DEPTH);

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       asm_q, asm_d;
  logic [7:0]        csum_q, csum_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept;
  logic [15:0]       lenNext;
  logic [31:0]       wordNext;

  // Handshake, status and core-release outputs are decoded directly from the state.
  always_comb begin
    byte_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                 (state_q == S_DATA)   || (state_q == S_CHECK);
    busy       = byte_ready;
    core_run   = (state_q == S_DONE);
    done       = done_q;
    err        = err_q;
    wr_en      = wren_q;
    wr_addr    = waddr_q;
    wr_data    = wdata_q;
    accept     = byte_valid && byte_ready;
    lenNext    = {len_q[15:8], byte_data};
    wordNext   = {asm_q[23:0], byte_data};
  end

  // Next-state logic: stream parsing, word assembly, checksum and write issue.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    csum_d  = csum_q;
    wren_d  = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LEN_HI;
          done_d  = 1'b0;
          err_d   = 1'b0;
          idx_d   = '0;
          csum_d  = '0;
          bcnt_d  = '0;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d   = {byte_data, 8'h00};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d = lenNext;
          if ({1'b0, lenNext} > DepthC) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else if (lenNext == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          asm_d  = wordNext;
          csum_d = csum_q ^ byte_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            wren_d  = 1'b1;
            waddr_d = idx_q[ADDR_W-1:0];
            wdata_d = wordNext;
            idx_d   = idx_q + 1'b1;
            if ((17'(idx_q) + 17'd1) == {1'b0, len_q}) begin
              state_d = S_CHECK;
            end
          end
        end
      end
      S_CHECK: begin
        if (accept) begin
          if (byte_data == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; a synchronous active-low reset aborts any load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      csum_q  <= '0;
      wren_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      csum_q  <= csum_d;
      wren_q  <= wren_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: a table of directed per-cycle vectors, followed by stream
// sequences that run against a small byte-stream model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        core_run;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] Gw0 = 32'h20080005;
  localparam logic [31:0] Gw1 = 32'h01095020;

  typedef struct {
    logic        rstN;
    logic        st;
    logic        vld;
    logic [7:0]  dat;
    logic        eWr;
    logic [7:0]  eAddr;
    logic [31:0] eData;
    logic        eRdy;
    logic        eBusy;
    logic        eDone;
    logic        eErr;
    logic        eRun;
  } vec_t;

  vec_t vecs [0:63];
  int   nVecs = 0;

  logic [7:0] streamBuf [0:15];
  int         streamLen;

  imem_loader #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .core_run(core_run),
    .busy(busy), .done(done), .err(err)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic w, input logic [7:0] a,
                          input logic [31:0] d, input logic rd, input logic b,
                          input logic dn, input logic e, input logic run);
    checkOutput({tag, " wr_en"}, 32'(wr_en), 32'(w));
    checkOutput({tag, " wr_addr"}, 32'(wr_addr), 32'(a));
    checkOutput({tag, " wr_data"}, wr_data, d);
    checkOutput({tag, " byte_ready"}, 32'(byte_ready), 32'(rd));
    checkOutput({tag, " busy"}, 32'(busy), 32'(b));
    checkOutput({tag, " done"}, 32'(done), 32'(dn));
    checkOutput({tag, " err"}, 32'(err), 32'(e));
    checkOutput({tag, " core_run"}, 32'(core_run), 32'(run));
  endtask

  task automatic addVec(input logic r, input logic s, input logic v, input logic [7:0] d,
                        input logic w, input logic [7:0] a, input logic [31:0] dt,
                        input logic rd, input logic b, input logic dn, input logic e,
                        input logic run);
    vecs[nVecs] = '{r, s, v, d, w, a, dt, rd, b, dn, e, run};
    nVecs++;
  endtask

  task automatic applyStimulus(input vec_t v);
    rst        = v.rstN;
    start      = v.st;
    byte_valid = v.vld;
    byte_data  = v.dat;
    tick();
  endtask

  // Sends streamBuf with an optional random byte_valid and an optional reset
  // abort, and predicts every write and the final status from the bytes alone.
  task automatic runStream(input bit randValid, input int abortAt, input bit pokeStart,
                           input string tag);
    int          sent = 0;
    int          cycles = 0;
    int          nWords;
    logic [31:0] asmW = '0;
    logic [7:0]  cs = '0;
    logic [7:0]  expAddr = '0;
    bit          v;
    bit          expWr;
    bit          good;
    nWords = int'({streamBuf[0], streamBuf[1]});
    start = 1'b1;
    byte_valid = 1'b0;
    tick();
    start = 1'b0;
    checkOutput({tag, " start busy"}, 32'(busy), 32'd1);
    checkOutput({tag, " start core_run"}, 32'(core_run), 32'd0);
    checkOutput({tag, " start done"}, 32'(done), 32'd0);
    while (sent < streamLen && cycles < 400) begin
      if (sent == abortAt) begin
        rst = 1'b0;
        byte_valid = 1'b0;
        tick();
        rst = 1'b1;
        checkAll({tag, " reset"}, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        return;
      end
      v = randValid ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_valid = v;
      byte_data  = streamBuf[sent];
      start      = pokeStart && (sent == 4);
      tick();
      expWr = 1'b0;
      if (v) begin
        if (sent >= 2 && sent < 2 + 4 * nWords) begin
          asmW = {asmW[23:0], streamBuf[sent]};
          cs   = cs ^ streamBuf[sent];
          if ((sent - 2) % 4 == 3) begin
            expWr   = 1'b1;
            expAddr = 8'((sent - 2) / 4);
          end
        end
        sent++;
      end
      checkOutput({tag, " wr_en"}, 32'(wr_en), 32'(expWr));
      if (expWr) begin
        checkOutput({tag, " wr_addr"}, 32'(wr_addr), 32'(expAddr));
        checkOutput({tag, " wr_data"}, wr_data, asmW);
      end
      cycles++;
    end
    byte_valid = 1'b0;
    start = 1'b0;
    if (sent < streamLen) begin
      total++;
      bad++;
      $display("[TB] FAIL %s timeout: sent %0d of %0d bytes", tag, sent, streamLen);
    end else begin
      good = (streamBuf[streamLen-1] == cs);
      checkOutput({tag, " end done"}, 32'(done), 32'(good));
      checkOutput({tag, " end err"}, 32'(err), 32'(!good));
      checkOutput({tag, " end core_run"}, 32'(core_run), 32'(good));
      checkOutput({tag, " end busy"}, 32'(busy), 32'd0);
      checkOutput({tag, " end byte_ready"}, 32'(byte_ready), 32'd0);
    end
  endtask

  // Guards against a stuck simulation.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Main sequence: the directed vector table, then the stream sequences.
  initial begin
    rst = 1'b0;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;

    // rst st vld dat | wr addr data | rdy busy done err run
    addVec(0, 0, 0, 8'h00, 0, 8'h00, 32'h0, 0, 0, 0, 0, 0);
    addVec(1, 0, 1, 8'hAA, 0, 8'h00, 32'h0, 0, 0, 0, 0, 0);
    addVec(1, 1, 0, 8'h00, 0, 8'h00, 32'h0, 1, 1, 0, 0, 0);
    addVec(1, 0, 1, 8'h00, 0, 8'h00, 32'h0, 1, 1, 0, 0, 0);
    addVec(1, 0, 1, 8'h02, 0, 8'h00, 32'h0, 1, 1, 0, 0, 0);
    addVec(1, 0, 1, 8'h20, 0, 8'h00, 32'h0, 1, 1, 0, 0, 0);
    addVec(1, 0, 1, 8'h08, 0, 8'h00, 32'h0, 1, 1, 0, 0, 0);
    addVec(1, 0, 1, 8'h00, 0, 8'h00, 32'h0, 1, 1, 0, 0, 0);
    addVec(1, 0, 1, 8'h05, 1, 8'h00, Gw0, 1, 1, 0, 0, 0);
    addVec(1, 0, 0, 8'h00, 0, 8'h00, Gw0, 1, 1, 0, 0, 0);
    addVec(1, 0, 1, 8'h01, 0, 8'h00, Gw0, 1, 1, 0, 0, 0);
    addVec(1, 0, 1, 8'h09, 0, 8'h00, Gw0, 1, 1, 0, 0, 0);
    addVec(1, 0, 1, 8'h50, 0, 8'h00, Gw0, 1, 1, 0, 0, 0);
    addVec(1, 0, 1, 8'h20, 1, 8'h01, Gw1, 1, 1, 0, 0, 0);
    addVec(1, 0, 1, 8'h55, 0, 8'h01, Gw1, 0, 0, 1, 0, 1);
    addVec(1, 0, 1, 8'hAA, 0, 8'h01, Gw1, 0, 0, 1, 0, 1);
    addVec(1, 1, 0, 8'h00, 0, 8'h01, Gw1, 1, 1, 0, 0, 0);
    addVec(1, 0, 1, 8'h00, 0, 8'h01, Gw1, 1, 1, 0, 0, 0);
    addVec(1, 0, 1, 8'h02, 0, 8'h01, Gw1, 1, 1, 0, 0, 0);
    addVec(1, 0, 1, 8'h20, 0, 8'h01, Gw1, 1, 1, 0, 0, 0);
    addVec(1, 0, 1, 8'h08, 0, 8'h01, Gw1, 1, 1, 0, 0, 0);
    addVec(1, 0, 1, 8'h00, 0, 8'h01, Gw1, 1, 1, 0, 0, 0);
    addVec(1, 0, 1, 8'h05, 1, 8'h00, Gw0, 1, 1, 0, 0, 0);
    addVec(1, 0, 1, 8'h01, 0, 8'h00, Gw0, 1, 1, 0, 0, 0);
    addVec(1, 0, 1, 8'h09, 0, 8'h00, Gw0, 1, 1, 0, 0, 0);
    addVec(1, 0, 1, 8'h50, 0, 8'h00, Gw0, 1, 1, 0, 0, 0);
    addVec(1, 0, 1, 8'h20, 1, 8'h01, Gw1, 1, 1, 0, 0, 0);
    addVec(1, 0, 1, 8'h54, 0, 8'h01, Gw1, 0, 0, 0, 1, 0);
    addVec(1, 1, 0, 8'h00, 0, 8'h01, Gw1, 1, 1, 0, 0, 0);
    addVec(1, 0, 1, 8'h00, 0, 8'h01, Gw1, 1, 1, 0, 0, 0);
    addVec(1, 0, 1, 8'h00, 0, 8'h01, Gw1, 1, 1, 0, 0, 0);
    addVec(1, 0, 1, 8'h00, 0, 8'h01, Gw1, 0, 0, 1, 0, 1);
    addVec(1, 1, 0, 8'h00, 0, 8'h01, Gw1, 1, 1, 0, 0, 0);
    addVec(1, 0, 1, 8'h01, 0, 8'h01, Gw1, 1, 1, 0, 0, 0);
    addVec(1, 0, 1, 8'h01, 0, 8'h01, Gw1, 0, 0, 0, 1, 0);
    addVec(1, 0, 1, 8'h5A, 0, 8'h01, Gw1, 0, 0, 0, 1, 0);

    for (int i = 0; i < nVecs; i++) begin
      applyStimulus(vecs[i]);
      checkAll($sformatf("vec%0d", i), vecs[i].eWr, vecs[i].eAddr, vecs[i].eData,
               vecs[i].eRdy, vecs[i].eBusy, vecs[i].eDone, vecs[i].eErr, vecs[i].eRun);
    end
    rst = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;

    streamBuf[0] = 8'h00; streamBuf[1] = 8'h02;
    streamBuf[2] = 8'h20; streamBuf[3] = 8'h08; streamBuf[4] = 8'h00; streamBuf[5] = 8'h05;
    streamBuf[6] = 8'h01; streamBuf[7] = 8'h09; streamBuf[8] = 8'h50; streamBuf[9] = 8'h20;
    streamBuf[10] = 8'h55;
    streamLen = 11;

    runStream(1'b1, -1, 1'b0, "randvalid");
    runStream(1'b0, 8, 1'b0, "abort");
    runStream(1'b0, -1, 1'b0, "restart");
    runStream(1'b0, -1, 1'b1, "pokestart");
    runStream(1'b0, -1, 1'b0, "reload");
    streamBuf[10] = 8'h54;
    runStream(1'b1, -1, 1'b0, "badcs");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
